// File: rtl/atomik_decoder.sv
// atomik_decoder: receive-side partner of the polymorphic scrambling core.
// It tracks the sender's xorshift32 keystream cycle for cycle, XORs each
// incoming ciphertext word with the current seed, and queues the plaintext
// in a small FIFO. FIFO_DEPTH must be a power of two and at least 2.
module atomik_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] scramble_threshold,
    input  logic [31:0] polymorph_seed,
    input  logic        otp_en,
    input  logic        seed_resync,
    input  logic [31:0] cipher_in,
    input  logic        cipher_valid,
    output logic [31:0] plain_out,
    output logic        plain_valid,
    input  logic        plain_ready,
    output logic        overflow,
    output logic [15:0] frame_count
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    // Keystream state, kept in lockstep with the transmitting core
    logic [31:0] seed;
    logic [31:0] timer;
    logic        cv_prev;
    logic        active;

    // Plaintext FIFO storage and extra-MSB pointers
    logic [31:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             overflow_q;
    logic [15:0]      frame_q;

    // Decoded control terms
    logic [31:0] seed_load;
    logic [31:0] xs1;
    logic [31:0] xs2;
    logic [31:0] xs3;
    logic [31:0] seed_rot;
    logic        thr_on;
    logic        end_of_txn;
    logic        rotate;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        push_ok;
    logic        drop;

    // Seed candidates, rotation decision and FIFO handshake terms
    always_comb begin
        seed_load  = (polymorph_seed == 32'd0) ? 32'hFFFF_FFFF : polymorph_seed;
        xs1        = seed ^ (seed << 13);
        xs2        = xs1 ^ (xs1 >> 17);
        xs3        = xs2 ^ (xs2 << 5);
        seed_rot   = (xs3 == 32'd0) ? 32'hFFFF_FFFF : xs3;
        thr_on     = (scramble_threshold != 32'd0);
        end_of_txn = cv_prev & ~cipher_valid;
        rotate     = (thr_on && (timer >= scramble_threshold)) || (otp_en && end_of_txn);
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
        pop        = rst_n & ~fifo_empty & plain_ready;
        push_ok    = cipher_valid & (~fifo_full | pop);
        drop       = cipher_valid & fifo_full & ~pop;
    end

    // Keystream advance: resync beats rotation, rotation beats zero-seed load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seed    <= 32'd0;
            timer   <= 32'd0;
            cv_prev <= 1'b0;
            active  <= 1'b0;
        end else if (seed_resync) begin
            seed    <= seed_load;
            timer   <= 32'd0;
            cv_prev <= 1'b0;
            active  <= 1'b0;
        end else begin
            cv_prev <= cipher_valid;
            if (cipher_valid) begin
                active <= 1'b1;
            end else if (end_of_txn) begin
                active <= 1'b0;
            end
            if (rotate) begin
                seed  <= seed_rot;
                timer <= 32'd0;
            end else begin
                if (seed == 32'd0) begin
                    seed <= seed_load;
                end
                if (thr_on && (active || cipher_valid)) begin
                    timer <= timer + 32'd1;
                end
            end
        end
    end

    // FIFO storage write of the decrypted word using the pre-edge seed
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= cipher_in ^ seed;
        end
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Saturating count of completed transactions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_q <= 16'd0;
        end else if (end_of_txn && (frame_q != 16'hFFFF)) begin
            frame_q <= frame_q + 16'd1;
        end
    end

    // Outputs are forced low while reset is held, even before the first edge
    assign plain_valid = rst_n & ~fifo_empty;
    assign plain_out   = plain_valid ? mem[rd_ptr[ADDR_W-1:0]] : 32'd0;
    assign overflow    = rst_n & overflow_q;
    assign frame_count = rst_n ? frame_q : 16'd0;

endmodule

// File: tb/tb_atomik_decoder.sv
// tb_atomik_decoder: directed checks of the decoder with hand-derived keys.
// Keys for polymorph_seed=1: 0x00000001, then xorshift32 gives 0x00042021,
// then 0x04080601.
module tb_atomik_decoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] scramble_threshold;
    logic [31:0] polymorph_seed;
    logic        otp_en;
    logic        seed_resync;
    logic [31:0] cipher_in;
    logic        cipher_valid;
    logic [31:0] plain_out;
    logic        plain_valid;
    logic        plain_ready;
    logic        overflow;
    logic [15:0] frame_count;

    int tests_run;
    int tests_failed;

    localparam logic [31:0] K1 = 32'h0000_0001;
    localparam logic [31:0] KA = 32'h0004_2021;
    localparam logic [31:0] KB = 32'h0408_0601;

    atomik_decoder #(.FIFO_DEPTH(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .scramble_threshold (scramble_threshold),
        .polymorph_seed     (polymorph_seed),
        .otp_en             (otp_en),
        .seed_resync        (seed_resync),
        .cipher_in          (cipher_in),
        .cipher_valid       (cipher_valid),
        .plain_out          (plain_out),
        .plain_valid        (plain_valid),
        .plain_ready        (plain_ready),
        .overflow           (overflow),
        .frame_count        (frame_count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference xorshift32 step used to derive keys for the zero-seed case
    function automatic logic [31:0] xs32(input logic [31:0] s);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        a = s ^ (s << 13);
        b = a ^ (a >> 17);
        c = b ^ (b << 5);
        return (c == 32'd0) ? 32'hFFFF_FFFF : c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cv, input logic [31:0] cin, input logic ready);
        cipher_valid = cv;
        cipher_in    = cin;
        plain_ready  = ready;
        tick();
    endtask

    // Two reset cycles, then one idle cycle in which the seed loads
    task automatic doReset(input logic [31:0] pseed);
        rst_n          = 1'b0;
        polymorph_seed = pseed;
        cipher_valid   = 1'b0;
        cipher_in      = 32'd0;
        plain_ready    = 1'b0;
        seed_resync    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [31:0] key;
        tests_run          = 0;
        tests_failed       = 0;
        rst_n              = 1'b0;
        scramble_threshold = 32'd0;
        polymorph_seed     = 32'd0;
        otp_en             = 1'b0;
        seed_resync        = 1'b0;
        cipher_in          = 32'd0;
        cipher_valid       = 1'b0;
        plain_ready        = 1'b0;

        // Outputs held low during reset, before any clock edge
        #3;
        checkOutput("rst_valid", 32'(plain_valid), 32'd0);
        checkOutput("rst_out", plain_out, 32'd0);
        checkOutput("rst_ovf", 32'(overflow), 32'd0);
        checkOutput("rst_frames", 32'(frame_count), 32'd0);

        // Single word with a fixed seed
        doReset(32'h1234_5678);
        applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("basic_valid", 32'(plain_valid), 32'd1);
        checkOutput("basic_out", plain_out, 32'hCC99_E897);
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("basic_drained", 32'(plain_valid), 32'd0);
        checkOutput("basic_frames", 32'(frame_count), 32'd1);

        // Zero polymorph seed, then OTP rotation over three transactions
        doReset(32'd0);
        otp_en = 1'b1;
        applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1);
        checkOutput("zseed_out", plain_out, 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1);
        key = xs32(32'hFFFF_FFFF);
        applyStimulus(1'b1, 32'h1111_1111 ^ key, 1'b1);
        checkOutput("otp_t2a", plain_out, 32'h1111_1111);
        applyStimulus(1'b1, 32'h2222_2222 ^ key, 1'b1);
        checkOutput("otp_t2b", plain_out, 32'h2222_2222);
        applyStimulus(1'b0, 32'd0, 1'b1);
        key = xs32(key);
        applyStimulus(1'b1, 32'h3333_3333 ^ key, 1'b1);
        checkOutput("otp_t3", plain_out, 32'h3333_3333);
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("otp_frames", 32'(frame_count), 32'd3);
        otp_en = 1'b0;

        // Threshold 4: words 1-5 use seed 1, words 6-10 use the first rotation
        doReset(K1);
        scramble_threshold = 32'd4;
        for (int k = 1; k <= 10; k++) begin
            key = (k <= 5) ? K1 : KA;
            applyStimulus(1'b1, (32'hA000_0000 + 32'(k)) ^ key, 1'b1);
            checkOutput($sformatf("thr_w%0d", k), plain_out, 32'hA000_0000 + 32'(k));
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        applyStimulus(1'b1, 32'hA000_000B ^ KB, 1'b1);
        checkOutput("thr_w11", plain_out, 32'hA000_000B);
        applyStimulus(1'b0, 32'd0, 1'b1);
        scramble_threshold = 32'd0;

        // Overflow: six words into a depth-4 FIFO, keystream keeps running
        doReset(K1);
        scramble_threshold = 32'd2;
        for (int k = 1; k <= 6; k++) begin
            key = (k <= 3) ? K1 : KA;
            applyStimulus(1'b1, (32'hB000_0000 + 32'(k)) ^ key, 1'b0);
        end
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_valid", 32'(plain_valid), 32'd1);
        checkOutput("ovf_w1", plain_out, 32'hB000_0001);
        for (int k = 2; k <= 4; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1);
            checkOutput($sformatf("ovf_w%0d", k), plain_out, 32'hB000_0000 + 32'(k));
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("ovf_empty", 32'(plain_valid), 32'd0);
        applyStimulus(1'b1, 32'hB000_0007 ^ KB, 1'b0);
        checkOutput("ovf_w7", plain_out, 32'hB000_0007);
        checkOutput("ovf_sticky", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b1);
        scramble_threshold = 32'd0;

        // Full FIFO with simultaneous push and pop
        doReset(K1);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, (32'hC000_0000 + 32'(k)) ^ K1, 1'b0);
        end
        applyStimulus(1'b1, 32'hC000_0005 ^ K1, 1'b1);
        checkOutput("full_pp_ovf", 32'(overflow), 32'd0);
        checkOutput("full_pp_w2", plain_out, 32'hC000_0002);
        for (int k = 3; k <= 5; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1);
            checkOutput($sformatf("full_pp_w%0d", k), plain_out, 32'hC000_0000 + 32'(k));
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("full_pp_empty", 32'(plain_valid), 32'd0);
        checkOutput("full_pp_ovf_end", 32'(overflow), 32'd0);

        // Resync in the same cycle as a threshold rotation and a push
        doReset(K1);
        scramble_threshold = 32'd1;
        applyStimulus(1'b1, 32'hD000_0001 ^ K1, 1'b0);
        applyStimulus(1'b1, 32'hD000_0002 ^ K1, 1'b0);
        applyStimulus(1'b1, 32'hD000_0003 ^ KA, 1'b0);
        seed_resync = 1'b1;
        applyStimulus(1'b1, 32'hD000_0004 ^ KA, 1'b0);
        seed_resync = 1'b0;
        checkOutput("rsync_valid", 32'(plain_valid), 32'd1);
        checkOutput("rsync_w1", plain_out, 32'hD000_0001);
        checkOutput("rsync_ovf", 32'(overflow), 32'd0);
        for (int k = 2; k <= 4; k++) begin
            applyStimulus(1'b0, 32'd0, 1'b1);
            checkOutput($sformatf("rsync_w%0d", k), plain_out, 32'hD000_0000 + 32'(k));
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("rsync_empty", 32'(plain_valid), 32'd0);
        applyStimulus(1'b1, 32'hD000_0005 ^ K1, 1'b0);
        checkOutput("rsync_w5", plain_out, 32'hD000_0005);
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("rsync_frames", 32'(frame_count), 32'd1);
        scramble_threshold = 32'd0;

        // Reset in the middle of a transaction discards queued words
        doReset(32'h1234_5678);
        applyStimulus(1'b1, 32'hE000_0001 ^ 32'h1234_5678, 1'b0);
        applyStimulus(1'b1, 32'hE000_0002 ^ 32'h1234_5678, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(plain_valid), 32'd0);
        checkOutput("midrst_out", plain_out, 32'd0);
        tick();
        tick();
        rst_n        = 1'b1;
        cipher_valid = 1'b0;
        tick();
        checkOutput("postrst_valid", 32'(plain_valid), 32'd0);
        checkOutput("postrst_frames", 32'(frame_count), 32'd0);
        applyStimulus(1'b1, 32'hE000_0003 ^ 32'h1234_5678, 1'b0);
        checkOutput("postrst_w3", plain_out, 32'hE000_0003);
        applyStimulus(1'b0, 32'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
